// File: rtl/leaf_mem_pkg.sv
// Shared types for the kd-tree leaf memory: loader FSM states, patch word
// type and the two address-order encodings.
package leaf_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_t;

  localparam int PATCH_DATA_WIDTH = 11;
  localparam int PATCH_ELEMS      = 5;

  typedef logic [PATCH_ELEMS*PATCH_DATA_WIDTH-1:0] patch_t;

  localparam logic LOAD_MODE_LEAF_MAJOR = 1'b0;
  localparam logic LOAD_MODE_BANK_MAJOR = 1'b1;

endpackage

// File: rtl/leaf_bank_ram.sv
// One patch bank: single synchronous write port plus NUM_READ_PORTS
// registered read ports; out-of-range leaf indices read back as zero.
module leaf_bank_ram #(
  parameter int WIDTH          = 55,
  parameter int DEPTH          = 64,
  parameter int ADDR_WIDTH     = 6,
  parameter int NUM_READ_PORTS = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 wr_en,
  input  logic [ADDR_WIDTH-1:0]                wr_addr,
  input  logic [WIDTH-1:0]                     wr_data,
  input  logic [NUM_READ_PORTS-1:0]            rd_en,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ_PORTS*WIDTH-1:0]      rd_data
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      data_p1;

    assign addr = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

    // read stage: registered output, held while the port is idle
    always_ff @(posedge clk) begin
      if (rst) begin
        data_p1 <= '0;
      end else if (rd_en[p]) begin
        data_p1 <= ({1'b0, addr} < DEPTH_L) ? mem[addr] : '0;
      end
    end

    assign rd_data[p*WIDTH +: WIDTH] = data_p1;
  end

endmodule

// File: rtl/leaf_bank_loader.sv
// Leaf memory for the ANN leaf-search stage: a valid/ready stream fills
// LEAF_SIZE banks in leaf-major or bank-major order; whole-leaf reads out.
module leaf_bank_loader
  import leaf_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 11,
  parameter int PATCH_SIZE     = 5,
  parameter int LEAF_SIZE      = 8,
  parameter int NUM_LEAVES     = 64,
  parameter int NUM_READ_PORTS = 2,
  parameter int ADDR_WIDTH     = $clog2(NUM_LEAVES)
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  load_start,
  input  logic                                                  load_mode,
  input  logic                                                  load_abort,
  input  logic                                                  in_valid,
  output logic                                                  in_ready,
  input  logic [PATCH_SIZE*DATA_WIDTH-1:0]                      in_patch,
  output logic                                                  load_busy,
  output logic                                                  load_done,
  output logic [$clog2(LEAF_SIZE*NUM_LEAVES+1)-1:0]             load_count,
  input  logic [NUM_READ_PORTS-1:0]                             rd_en,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0]                  rd_leaf,
  output logic [NUM_READ_PORTS-1:0]                             rd_valid,
  output logic [NUM_READ_PORTS*LEAF_SIZE*PATCH_SIZE*DATA_WIDTH-1:0] rd_data
);

  localparam int PW     = PATCH_SIZE*DATA_WIDTH;
  localparam int TOTAL  = LEAF_SIZE*NUM_LEAVES;
  localparam int CNT_W  = $clog2(TOTAL+1);
  localparam int BANK_W = (LEAF_SIZE > 1) ? $clog2(LEAF_SIZE) : 1;

  localparam logic [BANK_W-1:0]     BANK_MAX = BANK_W'(LEAF_SIZE-1);
  localparam logic [ADDR_WIDTH-1:0] LEAF_MAX = ADDR_WIDTH'(NUM_LEAVES-1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TOTAL-1);

  load_state_t           state;
  logic                  mode_q;
  logic [BANK_W-1:0]     bank_idx, bank_nxt;
  logic [ADDR_WIDTH-1:0] leaf_idx, leaf_nxt;
  logic                  accept;
  logic                  rd_allow;

  // abort wins over a same-cycle handshake; reset blocks the write too
  assign accept   = in_valid & in_ready & ~load_abort & ~rst;
  assign rd_allow = (state != ST_LOAD);

  always_comb begin
    bank_nxt = bank_idx;
    leaf_nxt = leaf_idx;
    if (mode_q == LOAD_MODE_LEAF_MAJOR) begin
      bank_nxt = (bank_idx == BANK_MAX) ? '0 : bank_idx + BANK_W'(1);
      if (bank_idx == BANK_MAX) begin
        leaf_nxt = (leaf_idx == LEAF_MAX) ? '0 : leaf_idx + ADDR_WIDTH'(1);
      end
    end else begin
      leaf_nxt = (leaf_idx == LEAF_MAX) ? '0 : leaf_idx + ADDR_WIDTH'(1);
      if (leaf_idx == LEAF_MAX) begin
        bank_nxt = (bank_idx == BANK_MAX) ? '0 : bank_idx + BANK_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b0;
      load_busy  <= 1'b0;
      load_done  <= 1'b0;
      load_count <= '0;
      mode_q     <= LOAD_MODE_LEAF_MAJOR;
      bank_idx   <= '0;
      leaf_idx   <= '0;
    end else begin
      load_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (load_start) begin
            state      <= ST_LOAD;
            mode_q     <= load_mode;
            load_count <= '0;
            bank_idx   <= '0;
            leaf_idx   <= '0;
            in_ready   <= 1'b1;
            load_busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (load_abort) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b0;
            load_busy <= 1'b0;
          end else if (accept) begin
            load_count <= load_count + CNT_W'(1);
            bank_idx   <= bank_nxt;
            leaf_idx   <= leaf_nxt;
            if (load_count == CNT_LAST) begin
              state     <= ST_DONE;
              in_ready  <= 1'b0;
              load_busy <= 1'b0;
              load_done <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= '0;
    end else begin
      rd_valid <= rd_en & {NUM_READ_PORTS{rd_allow}};
    end
  end

  logic [NUM_READ_PORTS*PW-1:0] bank_rd [LEAF_SIZE];

  for (genvar b = 0; b < LEAF_SIZE; b++) begin : g_bank
    leaf_bank_ram #(
      .WIDTH          (PW),
      .DEPTH          (NUM_LEAVES),
      .ADDR_WIDTH     (ADDR_WIDTH),
      .NUM_READ_PORTS (NUM_READ_PORTS)
    ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (accept && (bank_idx == BANK_W'(b))),
      .wr_addr (leaf_idx),
      .wr_data (in_patch),
      .rd_en   (rd_en & {NUM_READ_PORTS{rd_allow}}),
      .rd_addr (rd_leaf),
      .rd_data (bank_rd[b])
    );

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
      assign rd_data[(p*LEAF_SIZE + b)*PW +: PW] = bank_rd[b][p*PW +: PW];
    end
  end

endmodule

// File: tb/tb_leaf_bank_loader.sv
// Scoreboarded bench for leaf_bank_loader: directed loads, abort, reset
// mid-load and dual-port reads with hand-computed leaf contents.
module tb_leaf_bank_loader;
  import leaf_mem_pkg::*;

  localparam int LS    = 8;
  localparam int NL    = 64;
  localparam int NRP   = 2;
  localparam int AW    = 6;
  localparam int PW    = 55;
  localparam int LW    = LS*PW;
  localparam int CW    = 10;
  localparam int TOTAL = LS*NL;

  typedef logic [LW-1:0] leaf_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                load_start = 1'b0;
  logic                load_mode = 1'b0;
  logic                load_abort = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  patch_t              in_patch = '0;
  logic                load_busy;
  logic                load_done;
  logic [CW-1:0]       load_count;
  logic [NRP-1:0]      rd_en = '0;
  logic [NRP*AW-1:0]   rd_leaf = '0;
  logic [NRP-1:0]      rd_valid;
  logic [NRP*LW-1:0]   rd_data;

  int    checks = 0;
  int    errors = 0;
  int    done_exp = 0;
  leaf_t q0[$];
  leaf_t q1[$];

  leaf_bank_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_mode  (load_mode),
    .load_abort (load_abort),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_patch   (in_patch),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_count (load_count),
    .rd_en      (rd_en),
    .rd_leaf    (rd_leaf),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic leaf_t m0(input int l);
    leaf_t v;
    for (int b = 0; b < LS; b++) v[b*PW +: PW] = PW'(LS*l + b);
    return v;
  endfunction

  function automatic leaf_t m1(input int l);
    leaf_t v;
    for (int b = 0; b < LS; b++) v[b*PW +: PW] = PW'(NL*b + l);
    return v;
  endfunction

  // monitor: pops the scoreboard whenever the DUT presents a response
  always @(negedge clk) begin
    if (load_done) begin
      if (done_exp == 0) chk("load_done_spurious", 1024'(1), 1024'(0));
      else begin
        checks++;
        done_exp--;
      end
    end
    if (rd_valid[0]) begin
      if (q0.size() == 0) chk("rd0_spurious_valid", 1024'(1), 1024'(0));
      else chk("rd0_data", 1024'(rd_data[LW-1:0]), 1024'(q0.pop_front()));
    end
    if (rd_valid[1]) begin
      if (q1.size() == 0) chk("rd1_spurious_valid", 1024'(1), 1024'(0));
      else chk("rd1_data", 1024'(rd_data[2*LW-1:LW]), 1024'(q1.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic mode);
    load_start = 1'b1;
    load_mode  = mode;
    tick();
    load_start = 1'b0;
  endtask

  task automatic stream(input int base, input int count, input bit gaps, input bit probe_rd);
    int n = 0;
    int cyc = 0;
    int rdy_bad = 0;
    bit probed = 0;
    bit v;
    bit acc;
    while (n < count && cyc < 4*count + 16) begin
      v = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_valid = v;
      in_patch = PW'(base + n);
      if (load_busy && !in_ready) rdy_bad++;
      acc = v && in_ready;
      if (acc && n == TOTAL-1) done_exp++;
      if (probe_rd && !probed && n == 5) begin
        rd_en   = 2'b11;
        rd_leaf = {AW'(2), AW'(1)};
        probed  = 1;
      end
      tick();
      if (rd_en != 0) begin
        rd_en = '0;
        chk("rd_valid_in_load", 1024'(rd_valid), 1024'(0));
      end
      if (acc) n++;
      cyc++;
    end
    in_valid = 1'b0;
    if (n < count) chk("stream_timeout", 1024'(n), 1024'(count));
    chk("in_ready_during_load", 1024'(rdy_bad), 1024'(0));
  endtask

  task automatic rd(input logic [1:0] en, input int l0, input int l1, input leaf_t e0, input leaf_t e1);
    rd_en   = en;
    rd_leaf = {AW'(l1), AW'(l0)};
    if (en[0]) q0.push_back(e0);
    if (en[1]) q1.push_back(e1);
    tick();
    rd_en = '0;
    chk("rd_valid", 1024'(rd_valid), 1024'(en));
  endtask

  initial begin
    leaf_t e;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_in_ready", 1024'(in_ready), 1024'(0));
    chk("reset_load_busy", 1024'(load_busy), 1024'(0));
    chk("reset_load_done", 1024'(load_done), 1024'(0));
    chk("reset_load_count", 1024'(load_count), 1024'(0));
    chk("reset_rd_valid", 1024'(rd_valid), 1024'(0));
    chk("reset_rd_data", 1024'(rd_data), 1024'(0));

    // mode 0 full load
    start_load(LOAD_MODE_LEAF_MAJOR);
    chk("in_ready_after_start", 1024'(in_ready), 1024'(1));
    stream(0, TOTAL, 1'b0, 1'b0);
    tick();
    chk("m0_done_seen", 1024'(done_exp), 1024'(0));
    chk("m0_load_count", 1024'(load_count), 1024'(TOTAL));
    rd(2'b01, 3, 0, m0(3), '0);

    // mode 1 full load, read issued in DONE sees the final write
    start_load(LOAD_MODE_BANK_MAJOR);
    stream(0, TOTAL, 1'b0, 1'b1);
    rd(2'b10, 0, 63, '0, m1(63));
    chk("m1_done_seen", 1024'(done_exp), 1024'(0));
    chk("m1_load_count", 1024'(load_count), 1024'(TOTAL));
    rd(2'b11, 3, 3, m1(3), m1(3));

    // abort after 10 handshakes with a handshake pending
    start_load(LOAD_MODE_LEAF_MAJOR);
    stream(0, 10, 1'b0, 1'b0);
    in_valid   = 1'b1;
    in_patch   = PW'(10);
    load_abort = 1'b1;
    tick();
    load_abort = 1'b0;
    in_valid   = 1'b0;
    chk("abort_load_busy", 1024'(load_busy), 1024'(0));
    chk("abort_in_ready", 1024'(in_ready), 1024'(0));
    chk("abort_load_count", 1024'(load_count), 1024'(10));
    tick();
    tick();
    chk("abort_count_held", 1024'(load_count), 1024'(10));
    e = m1(1);
    e[0 +: PW]  = PW'(8);
    e[PW +: PW] = PW'(9);
    rd(2'b10, 0, 1, '0, e);

    // mode 0 with random input gaps
    start_load(LOAD_MODE_LEAF_MAJOR);
    stream(0, TOTAL, 1'b1, 1'b0);
    tick();
    chk("gap_done_seen", 1024'(done_exp), 1024'(0));
    rd(2'b11, 0, 3, m0(0), m0(3));
    rd(2'b01, 63, 0, m0(63), '0);

    // dual reads
    rd(2'b11, 5, 5, m0(5), m0(5));
    rd(2'b11, 0, 63, m0(0), m0(63));

    // reset mid-load
    start_load(LOAD_MODE_LEAF_MAJOR);
    stream(2000, 100, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk("rst_load_busy", 1024'(load_busy), 1024'(0));
    chk("rst_in_ready", 1024'(in_ready), 1024'(0));
    chk("rst_load_done", 1024'(load_done), 1024'(0));
    chk("rst_load_count", 1024'(load_count), 1024'(0));
    chk("rst_rd_valid", 1024'(rd_valid), 1024'(0));
    chk("rst_rd_data", 1024'(rd_data), 1024'(0));
    rst = 1'b0;
    tick();
    for (int b = 0; b < LS; b++) e[b*PW +: PW] = PW'(2000 + b);
    rd(2'b01, 0, 0, e, '0);
    e = m0(12);
    for (int b = 0; b < 4; b++) e[b*PW +: PW] = PW'(2096 + b);
    rd(2'b10, 0, 12, '0, e);
    tick();
    tick();

    chk("q0_drained", 1024'(q0.size()), 1024'(0));
    chk("q1_drained", 1024'(q1.size()), 1024'(0));
    chk("done_pending", 1024'(done_exp), 1024'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
